// File: rtl/muldiv_unit.sv
// Iterative RV-M multiply/divide unit: one product/quotient bit per cycle, shared datapath.
// Latency: out_valid rises XLEN+1 edges after accept (1 edge for trivial operands with early-out).
// Backpressure: result and out_valid hold while out_ready is low; in_ready=0 until the result drains.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready + rs1/rs2/ctrl (funct3 op) on input;
//        flush aborts the current op; out_valid/out_ready + rd/z on output (z = rd==0).
// Optional feature: define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow
//        and multiply-by-zero one edge after accept.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      ctrl,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            z
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] p_q, p_d;        // {acc/remainder, multiplier/quotient}
  logic [2:0]        op_q, op_d;
  logic              neg_lo_q, neg_lo_d;  // negate product / quotient
  logic              neg_hi_q, neg_hi_d;  // negate remainder
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              z_q, z_d;

  // Operand decode, only meaningful on an accepting edge
  logic            accept, is_div, a_signed, b_signed, neg_a, neg_b, b_zero, early;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    is_div = ctrl[2];
    if (is_div) begin
      a_signed = ~ctrl[0];
      b_signed = ~ctrl[0];
    end else begin
      a_signed = (ctrl[1:0] != 2'b11);  // MULHU is the only multiply with unsigned rs1
      b_signed = ~ctrl[1];              // MULHSU and MULHU take rs2 as unsigned
    end
    neg_a  = a_signed & rs1[XLEN-1];
    neg_b  = b_signed & rs2[XLEN-1];
    mag_a  = neg_a ? -rs1 : rs1;
    mag_b  = neg_b ? -rs2 : rs2;
    b_zero = (rs2 == '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  assign early = is_div ? (b_zero || (~ctrl[0] && (rs1 == MIN_NEG) && (rs2 == {XLEN{1'b1}})))
                        : ((rs1 == '0) || b_zero);
`else
  assign early = 1'b0;
`endif

  // One iteration of shift-add multiply or restoring divide
  logic [XLEN:0]     add_sum, rem_sh;
  logic [XLEN-1:0]   rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] p_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;

  always_comb begin
    add_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
    rem_sh   = p_q[2*XLEN-1:XLEN-1];
    rem_ge   = (rem_sh >= {1'b0, a_q});
    // When rem_ge holds the true difference is below the divisor, so XLEN bits suffice
    rem_diff = rem_sh[XLEN-1:0] - a_q;
    if (op_q[2]) begin
      p_step = rem_ge ? {rem_diff, p_q[XLEN-2:0], 1'b1}
                      : {rem_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
    end else begin
      p_step = {add_sum, p_q[XLEN-1:1]};
    end

    prod_fix = neg_lo_q ? -p_q : p_q;
    quo_fix  = neg_lo_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    rem_fix  = neg_hi_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo_fix;
      default:                result = rem_fix;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready && !flush;

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    p_d      = p_q;
    op_d     = op_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    rd_d     = rd_q;
    z_d      = z_q;

    case (state_q)
      IDLE: ;
      BUSY: begin
        if (cnt_q != '0) begin
          p_d   = p_step;
          cnt_d = cnt_q - CW'(1);
        end else begin
          rd_d    = result;
          z_d     = (result == '0);
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = BUSY;
      op_d    = ctrl;
      a_d     = is_div ? mag_b : mag_a;
      // A zero count makes the next edge finalize straight from the preloaded p
      cnt_d   = early ? '0 : CW'(XLEN);
      if (is_div) begin
        // Divide-by-zero quotient stays all ones, so it is never negated
        neg_lo_d = (neg_a ^ neg_b) && !b_zero;
        neg_hi_d = neg_a;
        // Preload matches what the full iteration would leave: quotient all ones,
        // remainder = dividend. Overflow already finishes with {0, dividend}.
        p_d = (early && b_zero) ? {mag_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, mag_a};
      end else begin
        neg_lo_d = neg_a ^ neg_b;
        neg_hi_d = 1'b0;
        p_d      = early ? '0 : {{XLEN{1'b0}}, mag_b};
      end
    end

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      p_q      <= '0;
      op_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      rd_q     <= '0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      p_q      <= p_d;
      op_q     <= op_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      rd_q     <= rd_d;
      z_q      <= z_d;
    end
  end

  assign rd = rd_q;
  assign z  = z_q;

endmodule
